// File: rtl/riscv_pkg.sv
// Shared encodings for the writeback stage: load funct3 codes, result-select
// codes and the writeback FSM state type.
package riscv_pkg;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    localparam logic [1:0] WbSelAlu  = 2'b00;
    localparam logic [1:0] WbSelLoad = 2'b01;
    localparam logic [1:0] WbSelPc4  = 2'b10;
    localparam logic [1:0] WbSelRsvd = 2'b11;

    typedef enum logic [1:0] {
        StEmpty    = 2'd0,
        StWaitData = 2'd1,
        StCommit   = 2'd2
    } wb_state_e;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/halfword/word from
// the returned memory word and sign- or zero-extends it according to funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_result = 32'h0;
        case (i_funct3)
            F3Lb:    o_result = sext8(w_byte);
            F3Lh:    o_result = sext16(w_half);
            F3Lw:    o_result = i_word;
            F3Lbu:   o_result = {24'h0, w_byte};
            F3Lhu:   o_result = {16'h0, w_half};
            default: o_result = 32'h0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Pipeline writeback stage: latches MEM results, waits for load data when
// needed, then commits one register-file write with a matching bypass.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd,
    input  logic                 in_reg_write,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic [31:0]          in_alu_result,
    input  logic [31:0]          in_pc_plus4,
    input  logic                 dmem_rvalid,
    input  logic [31:0]          dmem_rdata,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [31:0]          fwd_data,
    output logic                 busy_load,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    wb_state_e r_state;
    wb_state_e w_state_next;

    logic [4:0]           r_rd;
    logic                 r_reg_write;
    logic [1:0]           r_wb_sel;
    logic [2:0]           r_funct3;
    logic [1:0]           r_addr_lo;
    logic [31:0]          r_alu_result;
    logic [31:0]          r_pc_plus4;
    logic [31:0]          r_load_data;
    logic [CNT_WIDTH-1:0] r_retire_cnt;

    logic        w_accept;
    logic        w_load_capture;
    logic [31:0] w_aligned;
    logic [31:0] w_result;

    assign in_ready       = (r_state != StWaitData);
    assign w_accept       = in_valid & in_ready;
    assign w_load_capture = (r_state == StWaitData) & dmem_rvalid;

    load_align u_load_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_word    (dmem_rdata),
        .o_result  (w_aligned)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    w_state_next = (in_wb_sel == WbSelLoad) ? StWaitData : StCommit;
                end
            end
            StWaitData: begin
                if (dmem_rvalid) begin
                    w_state_next = StCommit;
                end
            end
            StCommit: begin
                // A same-cycle accept keeps non-load throughput at one per cycle.
                if (w_accept) begin
                    w_state_next = (in_wb_sel == WbSelLoad) ? StWaitData : StCommit;
                end else begin
                    w_state_next = StEmpty;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_wb_sel     <= 2'b00;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_alu_result <= 32'h0;
            r_pc_plus4   <= 32'h0;
        end else if (w_accept) begin
            r_rd         <= in_rd;
            r_reg_write  <= in_reg_write;
            r_wb_sel     <= in_wb_sel;
            r_funct3     <= in_funct3;
            r_addr_lo    <= in_addr_lo;
            r_alu_result <= in_alu_result;
            r_pc_plus4   <= in_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_data <= 32'h0;
        end else if (w_load_capture) begin
            r_load_data <= w_aligned;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
        end else if (r_state == StCommit) begin
            r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
        end
    end

    // Result mux sees only latched fields, so no in_* path reaches the write port.
    always_comb begin
        w_result = 32'h0;
        case (r_wb_sel)
            WbSelAlu:  w_result = r_alu_result;
            WbSelLoad: w_result = r_load_data;
            WbSelPc4:  w_result = r_pc_plus4;
            WbSelRsvd: w_result = 32'h0;
            default:   w_result = 32'h0;
        endcase
    end

    assign rf_wen     = (r_state == StCommit) & r_reg_write & (r_rd != 5'd0);
    assign rf_waddr   = r_rd;
    assign rf_wdata   = w_result;
    assign fwd_valid  = rf_wen;
    assign fwd_rd     = r_rd;
    assign fwd_data   = w_result;
    assign busy_load  = (r_state == StWaitData);
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a negedge
// monitor pops and checks each register-file write it observes.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        in_ready, rf_wen, fwd_valid, busy_load;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data, retire_cnt;

    logic        d4_in_ready, d4_rf_wen, d4_fwd_valid, d4_busy_load;
    logic [4:0]  d4_rf_waddr, d4_fwd_rd;
    logic [31:0] d4_rf_wdata, d4_fwd_data;
    logic [3:0]  d4_retire_cnt;

    always #5 clk = ~clk;

    wb_stage #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .busy_load(busy_load), .retire_cnt(retire_cnt)
    );

    wb_stage #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_wen(d4_rf_wen),
        .rf_waddr(d4_rf_waddr), .rf_wdata(d4_rf_wdata), .fwd_valid(d4_fwd_valid),
        .fwd_rd(d4_fwd_rd), .fwd_data(d4_fwd_data), .busy_load(d4_busy_load),
        .retire_cnt(d4_retire_cnt)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (rf_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h, required no write",
                             rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {27'b0, rf_waddr}, {27'b0, e.rd});
                    chk("wr_data", rf_wdata, e.data);
                    chk("fwd_valid", {31'b0, fwd_valid}, 32'd1);
                    chk("fwd_rd", {27'b0, fwd_rd}, {27'b0, e.rd});
                    chk("fwd_data", fwd_data, e.data);
                end
            end else begin
                chk("fwd_valid_idle", {31'b0, fwd_valid}, 32'd0);
            end
        end
    end

    task automatic send_op(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                           input logic [2:0] f3, input logic [1:0] alo,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [31:0] exp_data);
        exp_t e;
        int   t;
        t             = 0;
        in_valid      = 1'b1;
        in_rd         = rd;
        in_reg_write  = rw;
        in_wb_sel     = sel;
        in_funct3     = f3;
        in_addr_lo    = alo;
        in_alu_result = alu;
        in_pc_plus4   = pc4;
        if (rw && rd != 5'd0) begin
            e.rd   = rd;
            e.data = exp_data;
            exp_q.push_back(e);
        end
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=%b, required 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        exp_cnt++;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                           input logic [31:0] word, input logic [31:0] exp_data);
        send_op(rd, 1'b1, 2'b01, f3, alo, 32'hDEAD_0000, 32'h0, exp_data);
        in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("busy_load_wait", {31'b0, busy_load}, 32'd1);
            chk("in_ready_wait", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("busy_load_commit", {31'b0, busy_load}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        in_valid    = 1'b0;
        dmem_rvalid = 1'b0;
        exp_q.delete();
        exp_cnt     = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_wb_sel = '0;
        in_funct3 = '0; in_addr_lo = '0; in_alu_result = '0; in_pc_plus4 = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        #2;
        chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
        chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("rst_busy_load", {31'b0, busy_load}, 32'd0);
        chk("rst_waddr", {27'b0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Single ALU op: one write pulse, count 1.
        send_op(5'd5, 1'b1, 2'b00, 3'b000, 2'b00, 32'h1234_5678, 32'h0, 32'h1234_5678);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_after_alu", retire_cnt, 32'd1);

        // Loads across every funct3 flavour.
        do_load(5'd7,  3'b000, 2'd3, 32'h80AA_BBCC, 32'hFFFF_FF80);
        do_load(5'd8,  3'b100, 2'd3, 32'h80AA_BBCC, 32'h0000_0080);
        do_load(5'd9,  3'b001, 2'd2, 32'h80AA_BBCC, 32'hFFFF_80AA);
        do_load(5'd10, 3'b010, 2'd1, 32'h80AA_BBCC, 32'h80AA_BBCC);
        do_load(5'd11, 3'b101, 2'd0, 32'h80AA_BBCC, 32'h0000_BBCC);
        do_load(5'd12, 3'b011, 2'd0, 32'h80AA_BBCC, 32'h0000_0000);
        do_load(5'd13, 3'b000, 2'd1, 32'h80AA_BBCC, 32'hFFFF_FFBB);
        chk("cnt_after_loads", retire_cnt, 32'(exp_cnt));

        // JAL link value, reserved select, and a non-writing op.
        send_op(5'd1, 1'b1, 2'b10, 3'b000, 2'b00, 32'h0000_AAAA, 32'h0000_0104, 32'h0000_0104);
        send_op(5'd3, 1'b1, 2'b11, 3'b000, 2'b00, 32'h0000_5555, 32'h0000_0999, 32'h0);
        send_op(5'd4, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0000_7777, 32'h0, 32'h0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_after_misc", retire_cnt, 32'(exp_cnt));

        // Back-to-back ALU ops to x1, x2, x0.
        do_reset();
        send_op(5'd1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000_0011, 32'h0, 32'h0000_0011);
        chk("b2b_wen_1", {31'b0, rf_wen}, 32'd1);
        send_op(5'd2, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000_0022, 32'h0, 32'h0000_0022);
        chk("b2b_wen_2", {31'b0, rf_wen}, 32'd1);
        chk("b2b_waddr_2", {27'b0, rf_waddr}, 32'd2);
        send_op(5'd0, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000_0033, 32'h0, 32'h0000_0033);
        chk("b2b_wen_0", {31'b0, rf_wen}, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_cnt", retire_cnt, 32'd3);

        // Reset while waiting on load data, then a stray rvalid.
        send_op(5'd6, 1'b1, 2'b01, 3'b010, 2'b00, 32'h0, 32'h0, 32'hCAFE_F00D);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = 0;
        chk("midrst_busy", {31'b0, busy_load}, 32'd0);
        chk("midrst_cnt", retire_cnt, 32'd0);
        chk("midrst_waddr", {27'b0, rf_waddr}, 32'd0);
        chk("midrst_wdata", rf_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_rf_wen", {31'b0, rf_wen}, 32'd0);
            chk("stray_busy", {31'b0, busy_load}, 32'd0);
            chk("stray_ready", {31'b0, in_ready}, 32'd1);
        end
        chk("stray_cnt", retire_cnt, 32'd0);

        // Narrow counter wraps after 16 commits.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_op(5'(i), 1'b0, 2'b00, 3'b000, 2'b00, 32'(i), 32'h0, 32'h0);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_cnt4", {28'b0, d4_retire_cnt}, 32'd1);
        chk("wrap_cnt32", retire_cnt, 32'd17);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of retire counter.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have in_valid  input  1  MEM stage presents an instruction.
REQ-005 SHALL have in_ready  output  1  stage accepts instruction this cycle.
REQ-006 SHALL have in_rd  input  5; in_reg_write  input  1; in_wb_sel  input  2 (00 ALU, 01 load, 10 PC+4, 11 reserved).
REQ-007 SHALL have in_funct3  input  3; in_addr_lo  input  2 (load byte offset); in_alu_result  input  32; in_pc_plus4  input  32.
REQ-008 SHALL have dmem_rvalid  input  1 and dmem_rdata  input  32, the load word return from data memory.
REQ-009 SHALL have rf_wen  output  1; rf_waddr  output  5; rf_wdata  output  32, the register file write port.
REQ-010 SHALL have fwd_valid  output  1; fwd_rd  output  5; fwd_data  output  32, the bypass to ID/EX.
REQ-011 SHALL have busy_load  output  1 (waiting on load data) and retire_cnt  output  CNT_WIDTH.

Function
REQ-012 SHALL implement FSM states EMPTY, WAIT_DATA, COMMIT.
REQ-013 in_ready SHALL be 1 in EMPTY and COMMIT, 0 in WAIT_DATA.
REQ-014 On accept (in_valid & in_ready) SHALL latch all in_* fields; next state WAIT_DATA if in_wb_sel=01, else COMMIT.
REQ-015 WAIT_DATA: on dmem_rvalid=1 SHALL latch aligned load result and go to COMMIT; otherwise hold, no timeout.
REQ-016 dmem_rvalid in EMPTY or COMMIT SHALL be ignored.
REQ-017 COMMIT lasts exactly one cycle; next state from a same-cycle accept per REQ-014, else EMPTY (back-to-back throughput 1/cycle for non-loads).
REQ-018 rf_wen SHALL be 1 only in COMMIT with latched reg_write=1 and rd!=0; rf_waddr=latched rd, rf_wdata=result, driven from registered state (no combinational path from in_*).
REQ-019 Result select: 00 alu_result; 01 aligned load; 10 pc_plus4; 11 zero.
REQ-020 Load alignment on funct3: 000 LB sign-extend byte addr_lo; 001 LH sign-extend halfword addr_lo[1]; 010 LW full word, addr_lo ignored; 100 LBU, 101 LHU zero-extend; 011/110/111 result zero.
REQ-021 fwd_valid SHALL equal rf_wen; fwd_rd/fwd_data equal rf_waddr/rf_wdata.
REQ-022 busy_load SHALL be 1 exactly in WAIT_DATA.
REQ-023 retire_cnt SHALL increment by 1 each COMMIT cycle regardless of rf_wen, wrapping modulo 2^CNT_WIDTH.

Reset
REQ-024 rst=0 SHALL immediately force EMPTY, retire_cnt=0, rf_wen=0, fwd_valid=0, busy_load=0, rf_waddr=0, rf_wdata=0, latched fields zero.
REQ-025 Reset in WAIT_DATA SHALL discard the pending load; a later dmem_rvalid SHALL have no effect.
REQ-026 in_ready SHALL be 1 from first rising edge after rst deasserts.

Structure
REQ-027 Shared package riscv_pkg SHALL hold funct3 load constants, wb_sel encodings and FSM state encoding.
REQ-028 Load alignment SHALL be a combinational sub-module load_align (inputs funct3, addr_lo, word; output 32-bit result).
REQ-029 Block SHALL contain no memories; all storage is flops.

Verification
REQ-030 ALU op rd=5, alu_result=0x12345678 accepted cycle N -> rf_wen=1, waddr=5, wdata=0x12345678 in cycle N+1 only; retire_cnt=1.
REQ-031 LB addr_lo=3, dmem_rdata=0x80AA_BBCC returned 4 cycles later -> busy_load=1 for those cycles, in_ready=0, then wdata=0xFFFFFF80; LBU same -> 0x00000080; LH addr_lo=2 -> 0xFFFF80AA.
REQ-032 Three back-to-back ALU ops to rd=1,2,0 -> wen pulses 1,1,0 on consecutive cycles; retire_cnt=3.
REQ-033 rst=0 asserted mid WAIT_DATA, released, then stray dmem_rvalid=1 -> state EMPTY, rf_wen stays 0, retire_cnt=0.
REQ-034 CNT_WIDTH=4, 17 commits -> retire_cnt=1 (wrap); JAL wb_sel=10 pc_plus4=0x104 rd=1 -> wdata=0x104.
